mem_1r1w_masked_arbiter: RTL

Shares one lowered 1r1w masked memory (48x64, 8-bit mask granularity) between NUM_REQ read requesters and NUM_REQ write requesters, using valid/ready handshakes. Zero-fills the whole array after reset, then runs round-robin arbitration on the read port and on the write port independently. Supplies write-first bypass for same-cycle read/write collisions and checks address range. Sits directly in front of the memory wrapper's R0/W0 ports.

---
 rtl/mem_1r1w_masked_arbiter_pkg.sv | 36 +++
 rtl/mem_1r1w_masked_arbiter_rr_arbiter.sv | 51 +++++
 rtl/mem_1r1w_masked_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_1r1w_masked_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared geometry, state encoding and lane-merge helper for the
//            1r1w masked memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int DEPTH     = 48;
  localparam int WIDTH     = 64;
  localparam int MASK_GRAN = 8;
  localparam int MB        = WIDTH / MASK_GRAN;
  localparam int AW        = $clog2(DEPTH);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Per-lane select: lanes with mask set take new_data, others keep old_data.
  function automatic logic [WIDTH-1:0] lane_merge(
    input logic [WIDTH-1:0] old_data,
    input logic [WIDTH-1:0] new_data,
    input logic [MB-1:0]    mask
  );
    logic [WIDTH-1:0] merged;
    merged = old_data;
    for (int k = 0; k < MB; k++) begin
      if (mask[k]) merged[k*MASK_GRAN +: MASK_GRAN] = new_data[k*MASK_GRAN +: MASK_GRAN];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_1r1w_masked_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter. Search begins at the pointer; after a
//            grant the pointer moves to winner+1, otherwise it holds.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            j;

  // First requester at or after the pointer (wrapping) wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int off = 0; off < N; off++) begin
      j = int'(ptr) + off;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

  // Pointer steps past the winner only when a grant was actually issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_1r1w_masked_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_1r1w_masked_arbiter
// Brief    : Zero-fills a 1r1w masked memory after reset, then round-robin
//            arbitrates independent read and write ports with write-first
//            bypass on same-cycle same-address collisions.
// Revision : 1.0 - initial release
// ============================================================================
module mem_1r1w_masked_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       rd_valid,
  output logic [NUM_REQ-1:0]       rd_ready,
  input  logic [NUM_REQ*AW-1:0]    rd_addr,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  input  logic [NUM_REQ-1:0]       wr_valid,
  output logic [NUM_REQ-1:0]       wr_ready,
  input  logic [NUM_REQ*AW-1:0]    wr_addr,
  input  logic [NUM_REQ*WIDTH-1:0] wr_data,
  input  logic [NUM_REQ*MB-1:0]    wr_mask,
  output logic [AW-1:0]            R0_addr,
  output logic                     R0_en,
  input  logic [WIDTH-1:0]         R0_data,
  output logic [AW-1:0]            W0_addr,
  output logic                     W0_en,
  output logic [WIDTH-1:0]         W0_data,
  output logic [MB-1:0]            W0_mask,
  output logic                     init_busy,
  output logic                     oob_err
);

  localparam int            IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  state_t           state, state_nxt;
  logic [AW-1:0]    init_cnt;
  logic             run;

  logic [NUM_REQ-1:0] rd_grant, wr_grant;
  logic [IW-1:0]      rd_idx, wr_idx;
  logic [AW-1:0]      rd_sel_addr, wr_sel_addr;
  logic [WIDTH-1:0]   wr_sel_data;
  logic [MB-1:0]      wr_sel_mask;
  logic               rd_acc, wr_acc, rd_in_range, wr_in_range, rd_mem, wr_mem;

  logic               bypass_hit;
  logic [WIDTH-1:0]   bp_data;
  logic [MB-1:0]      bp_mask;

  assign run = (state == RUN);

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (rd_valid & {NUM_REQ{run}}),
    .advance (run),
    .grant   (rd_grant),
    .idx     (rd_idx)
  );

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (wr_valid & {NUM_REQ{run}}),
    .advance (run),
    .grant   (wr_grant),
    .idx     (wr_idx)
  );

  assign rd_ready    = rd_grant;
  assign wr_ready    = wr_grant;
  assign rd_sel_addr = rd_addr[rd_idx*AW +: AW];
  assign wr_sel_addr = wr_addr[wr_idx*AW +: AW];
  assign wr_sel_data = wr_data[wr_idx*WIDTH +: WIDTH];
  assign wr_sel_mask = wr_mask[wr_idx*MB +: MB];
  assign rd_acc      = |rd_grant;
  assign wr_acc      = |wr_grant;
  assign rd_in_range = ({1'b0, rd_sel_addr} < DEPTH_EXT);
  assign wr_in_range = ({1'b0, wr_sel_addr} < DEPTH_EXT);
  assign rd_mem      = rd_acc && rd_in_range;
  // A zero mask is consumed without touching the memory.
  assign wr_mem      = wr_acc && wr_in_range && (|wr_sel_mask);

  // State and fill-address register; reset restarts the fill at address 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT && init_cnt != LAST_ADDR) init_cnt <= init_cnt + 1'b1;
    end
  end

  // Next state and memory-port steering: fill writes in INIT, granted traffic in RUN.
  always_comb begin
    state_nxt = state;
    init_busy = 1'b0;
    R0_en     = 1'b0;
    R0_addr   = '0;
    W0_en     = 1'b0;
    W0_addr   = '0;
    W0_data   = '0;
    W0_mask   = '0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        W0_en     = 1'b1;
        W0_addr   = init_cnt;
        W0_mask   = '1;
        if (init_cnt == LAST_ADDR) state_nxt = RUN;
      end
      RUN: begin
        R0_en   = rd_mem;
        R0_addr = rd_mem ? rd_sel_addr : '0;
        W0_en   = wr_mem;
        W0_addr = wr_mem ? wr_sel_addr : '0;
        W0_data = wr_mem ? wr_sel_data : '0;
        W0_mask = wr_mem ? wr_sel_mask : '0;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Response bookkeeping: pulse, range error, sticky write error, collision capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid  <= '0;
      rsp_err    <= 1'b0;
      oob_err    <= 1'b0;
      bypass_hit <= 1'b0;
      bp_data    <= '0;
      bp_mask    <= '0;
    end else begin
      rsp_valid  <= rd_grant;
      rsp_err    <= rd_acc && !rd_in_range;
      bypass_hit <= rd_mem && wr_mem && (rd_sel_addr == wr_sel_addr);
      bp_data    <= wr_sel_data;
      bp_mask    <= wr_sel_mask;
      if (wr_acc && !wr_in_range) oob_err <= 1'b1;
    end
  end

  // Memory returns pre-write data on a collision, so written lanes are overlaid here.
  always_comb begin
    rsp_data = '0;
    if (|rsp_valid && !rsp_err) begin
      rsp_data = bypass_hit ? lane_merge(R0_data, bp_data, bp_mask) : R0_data;
    end
  end

endmodule
`default_nettype wire
